// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with parallel load, shift/rotate/clear
// and a burst engine that repeats one operation for a programmed length.
module shift_reg_univ #(
  parameter int              WIDTH     = 8,
  parameter int              CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LSR  = 3'b011;
  localparam logic [2:0] M_ASR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ROR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [2:0]       mode_lat, mode_lat_nxt;
  logic [2:0]       op_mode;
  logic             done_nxt;
  logic             apply;
  logic             len_zero, len_one;
  logic [WIDTH-1:0] q_nxt;

  function automatic logic [WIDTH-1:0] shift_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (m)
      M_HOLD:  r = v;
      M_LOAD:  r = ld;
      M_SHL:   r = {v[WIDTH-2:0], sr};
      M_LSR:   r = {sl, v[WIDTH-1:1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_CLR:   r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  assign len_zero = (len == '0);
  assign len_one  = (len == CNT_W'(1));

  // State register: FSM, burst counter, latched mode and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      mode_lat  <= M_HOLD;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      mode_lat  <= mode_lat_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic; everything holds while en is low
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    mode_lat_nxt  = mode_lat;
    done_nxt      = done;
    if (en) begin
      case (state)
        IDLE: begin
          done_nxt = start && (len_zero || len_one);
          if (start && !len_zero && !len_one) begin
            state_nxt     = BURST;
            remaining_nxt = len - CNT_W'(1);
            mode_lat_nxt  = mode;
          end
        end
        BURST: begin
          remaining_nxt = remaining - CNT_W'(1);
          done_nxt      = (remaining == CNT_W'(1));
          if (remaining == CNT_W'(1)) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: live mode in IDLE, latched mode in BURST; len=0 start is a no-op
  always_comb begin
    busy    = (state == BURST);
    op_mode = (state == BURST) ? mode_lat : mode;
    apply   = en && !((state == IDLE) && start && len_zero);
    q_nxt   = apply ? shift_op(op_mode, q, d, sin_l, sin_r) : q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ (WIDTH=8, CNT_W=4, RESET_VAL=0x3C):
// each driven cycle pushes its expected q/busy/done; a monitor pops and compares.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l, sin_r, start;
  logic [3:0] len;
  logic [7:0] q;
  logic       sout_l, sout_r, busy, done;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
    int         id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_id = 0;

  shift_reg_univ #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h3C)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .len(len),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge and record what must appear after the next rising edge
  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sr, input logic st, input logic [3:0] ln,
                      input logic [7:0] eq, input logic eb, input logic ed);
    exp_t x;
    @(negedge clk);
    rst_n = 1'b1;
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr; start = st; len = ln;
    step_id++;
    x.q = eq; x.busy = eb; x.done = ed; x.id = step_id;
    sb.push_back(x);
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, "_q"},      q,      32'h3C);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
    check({tag, "_sout_l"}, sout_l, 0);
    check({tag, "_sout_r"}, sout_r, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check($sformatf("s%0d_q", mon_e.id),      q,      mon_e.q);
      check($sformatf("s%0d_busy", mon_e.id),   busy,   mon_e.busy);
      check($sformatf("s%0d_done", mon_e.id),   done,   mon_e.done);
      check($sformatf("s%0d_sout_l", mon_e.id), sout_l, mon_e.q[7]);
      check($sformatf("s%0d_sout_r", mon_e.id), sout_r, mon_e.q[0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    rst_n = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; len = 4'd0;
    repeat (2) @(negedge clk);
    check_reset_now("por");
    rst_n = 1'b1;

    // Reset pulse between edges takes effect without a clock
    step(1, 3'b001, 8'h77, 0, 0, 0, 0, 8'h77, 0, 0);
    @(negedge clk);
    en = 1'b0; start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_now("pulse");
    #1;
    rst_n = 1'b1;
    step_id++;
    x.q = 8'h3C; x.busy = 1'b0; x.done = 1'b0; x.id = step_id;
    sb.push_back(x);

    // Single operations
    step(1, 3'b001, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0);
    step(1, 3'b010, 8'h00, 0, 1, 0, 0, 8'h4B, 0, 0);
    step(1, 3'b001, 8'h96, 0, 0, 0, 0, 8'h96, 0, 0);
    step(1, 3'b100, 8'h00, 0, 0, 0, 0, 8'hCB, 0, 0);
    step(1, 3'b001, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0);
    step(1, 3'b110, 8'h00, 0, 0, 0, 0, 8'hC0, 0, 0);
    step(1, 3'b111, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 3'b001, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0);
    step(1, 3'b000, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0);

    // Burst rotate left len=3; live mode/start changes mid-burst are ignored
    step(1, 3'b001, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0);
    step(1, 3'b101, 8'h00, 0, 0, 1, 3, 8'h03, 1, 0);
    step(1, 3'b111, 8'h00, 0, 0, 1, 0, 8'h06, 1, 0);
    step(1, 3'b001, 8'hFF, 0, 0, 1, 7, 8'h0C, 0, 1);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 0);

    // len=0 and len=1
    step(1, 3'b001, 8'hFF, 0, 0, 1, 0, 8'h0C, 0, 1);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 0);
    step(1, 3'b111, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    step(1, 3'b011, 8'h00, 1, 0, 1, 1, 8'h80, 0, 1);

    // Stalled burst shift left len=4, start ignored while en=0
    step(1, 3'b001, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0);
    step(1, 3'b010, 8'h00, 0, 0, 1, 4, 8'h02, 1, 0);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h04, 1, 0);
    step(0, 3'b001, 8'hFF, 0, 1, 1, 2, 8'h04, 1, 0);
    step(0, 3'b001, 8'hFF, 0, 1, 1, 2, 8'h04, 1, 0);
    step(0, 3'b001, 8'hFF, 0, 1, 1, 2, 8'h04, 1, 0);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h08, 1, 0);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h10, 0, 1);

    // Back-to-back burst started while done is high
    step(1, 3'b101, 8'h00, 0, 0, 1, 2, 8'h20, 1, 0);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h40, 0, 1);
    step(0, 3'b000, 8'h00, 0, 0, 0, 0, 8'h40, 0, 1);
    step(1, 3'b001, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0);

    // Reset during the third op of a len=5 burst
    step(1, 3'b101, 8'h00, 0, 0, 1, 5, 8'h02, 1, 0);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h04, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1; start = 1'b0; mode = 3'b000;
    #1;
    check_reset_now("midburst");
    step_id++;
    x.q = 8'h3C; x.busy = 1'b0; x.done = 1'b0; x.id = step_id;
    sb.push_back(x);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0);
    step(1, 3'b101, 8'h00, 0, 0, 1, 2, 8'h78, 1, 0);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'hF0, 0, 1);
    step(1, 3'b000, 8'h00, 0, 0, 0, 0, 8'hF0, 0, 0);

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: the next generation of the team's single-bit D flip-flop. It holds a WIDTH-bit word and supports hold, parallel load, logical/arithmetic/rotate shifts and clear, with serial inputs and outputs at both ends. A burst engine repeats one operation for a programmed number of cycles and reports busy/done. It is intended for serialisers, deserialisers, LFSR front-ends and bit-banged peripheral datapaths.

## Interface
- WIDTH, 8: register width in bits; must be ≥ 2.
- CNT_W, 4: width of the burst length field; the maximum burst is 2^CNT_W − 1 operations.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on reset.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0, all state (q, FSM, counter) holds.
- mode  input  3  operation select (see Operation).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the MSB on logical right shift.
- sin_r  input  1  serial input entering at the LSB on left shift.
- start  input  1  request a burst of `len` operations using the current `mode`.
- len  input  CNT_W  burst length.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse marking burst completion.

## Operation
- Mode encoding:
  - 000: hold.
  - 001: load q ← d.
  - 010: shift left, q ← {q[W-2:0], sin_r}.
  - 011: logical shift right, q ← {sin_l, q[W-1:1]}.
  - 100: arithmetic shift right, q ← {q[W-1], q[W-1:1]}.
  - 101: rotate left.
  - 110: rotate right.
  - 111: clear, q ← 0.
- FSM states:
  - IDLE: each en=1 edge with start=0 applies `mode` once (single-op mode).
  - BURST: each en=1 edge applies the latched burst mode. The live `mode`, `start` and `len` inputs are ignored.
- IDLE, en=1, start=1, len=N:
  - N=0: no operation, q holds; done=1 after the edge; stay in IDLE.
  - N=1: apply `mode` once; done=1 after the edge; stay in IDLE.
  - N≥2: apply `mode` (first op), latch the mode, set remaining ← N−1, enter BURST.
- BURST, en=1: apply the latched mode and decrement remaining. When remaining is 1 at the edge: apply the mode, set done ← 1, return to IDLE.
- Serial inputs sin_l/sin_r are sampled live on every shift, including during a burst.
- busy = (state == BURST).
- done is registered. It is high for exactly one cycle (one en=1 edge) and clears on the next en=1 edge. With en=0, done holds.
- Reset (rst_n=0, any time, including mid-burst), effective immediately without a clock:
  - q = RESET_VAL
  - state = IDLE, remaining = 0
  - busy = 0, done = 0
  - An aborted burst produces no done.

## Timing
- Single-op latency: q reflects the operation after the rising edge at which it is sampled; there is no pipeline.
- Burst of N ≥ 1: N consecutive en=1 edges, starting with the start edge.
  - busy is high for the N−1 cycles after the start edge.
  - done rises at the edge of the Nth operation, coincident with the final q value.
- en=0 for k cycles mid-burst stretches the burst by k cycles. q, remaining and busy all freeze.
- start=1 with en=0 is ignored.
- start=1 in the same cycle that done is high begins a new burst normally. This is back-to-back operation with no bubble.
- sout_l and sout_r follow q combinationally, with no extra latency.

## Test plan
- Reset with WIDTH=8, RESET_VAL=0x3C: pulse rst_n low between edges -> q=0x3C immediately; busy=0, done=0; sout_l=0, sout_r=0.
- Single ops: load 0xA5 -> 0xA5. Shift left with sin_r=1 -> 0x4B. Load 0x96, then arithmetic shift right -> 0xCB. Load 0x81, then rotate right -> 0xC0. Clear -> 0x00.
- Burst rotate left, len=3, from q=0x81 -> q=0x03, 0x06, 0x0C on successive edges. busy=1 for 2 cycles; done=1 only while q=0x0C. Changes to mode/start during the burst have no effect.
- Burst edge lengths:
  - len=0 -> q unchanged, one-cycle done, busy never high.
  - len=1, logical shift right with sin_l=1 from 0x00 -> 0x80 with done and no busy.
- Stall and back-to-back:
  - Burst shift left, len=4, from 0x01 with sin_r=0; deassert en for 3 cycles after the second op -> q holds at 0x04 and busy stays 1. Final q=0x10 with done.
  - Assert start with len=2 and rotate left while done is high -> q=0x20, then 0x40, with no idle cycle between the bursts.
- Reset mid-burst: assert rst_n low during the 3rd op of a len=5 burst -> q=RESET_VAL, busy=0, and no done pulse. A new burst after reset release operates normally.
